// File: rtl/dcache_ctrl.sv
// Blocking direct-mapped write-through / write-allocate data cache between the
// LSQ and the tagged memory bus; at most one memory transaction in flight.
module dcache_ctrl #(
  parameter int CACHE_LINES = 32,
  parameter int IDX_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  lsq_command,
  input  logic [31:0] lsq_addr,
  input  logic [31:0] lsq_store_data,
  output logic [3:0]  lsq_response,
  output logic [3:0]  lsq_tag,
  output logic [63:0] lsq_data_out,
  output logic [1:0]  proc2mem_command,
  output logic [31:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag
);
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;
  localparam int TAG_W = 32 - IDX_W - 3;

  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, STORE_REQ} state_t;
  state_t state, next_state;

  logic [CACHE_LINES-1:0] line_valid;
  logic [TAG_W-1:0]       line_tag  [CACHE_LINES];
  logic [63:0]            line_data [CACHE_LINES];

  logic [3:0]  next_tag, mem_tag, req_id;
  logic        req_is_store;
  logic [31:3] req_block;
  logic        req_word;
  logic [31:0] req_data;

  logic [IDX_W-1:0] lsq_idx, req_idx;
  logic [TAG_W-1:0] lsq_line_tag;
  logic             lsq_hit, lsq_is_load, lsq_is_store, fill_done;
  logic             accept, load_hit, line_we;
  logic [IDX_W-1:0] line_wr_idx;
  logic [TAG_W-1:0] line_wr_tag;
  logic [63:0]      line_wr_data;
  logic             unused_addr_bits;

  function automatic logic [63:0] merge_word(input logic [63:0] line, input logic sel,
                                             input logic [31:0] word);
    merge_word = sel ? {word, line[31:0]} : {line[63:32], word};
  endfunction

  function automatic logic [31:0] pick_word(input logic [63:0] line, input logic sel);
    pick_word = sel ? line[63:32] : line[31:0];
  endfunction

  assign lsq_idx          = lsq_addr[IDX_W+2:3];
  assign lsq_line_tag     = lsq_addr[31:IDX_W+3];
  assign req_idx          = req_block[IDX_W+2:3];
  assign lsq_is_load      = (lsq_command == BUS_LOAD);
  assign lsq_is_store     = (lsq_command == BUS_STORE);
  assign lsq_hit          = line_valid[lsq_idx] && (line_tag[lsq_idx] == lsq_line_tag);
  assign unused_addr_bits = ^lsq_addr[1:0];
  // A zero mem_tag means nothing is outstanding, so a zero bus tag can never match.
  assign fill_done = (state == FILL_WAIT) && (mem_tag != 4'd0) && (mem2proc_tag == mem_tag);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (lsq_hit)                        next_state = lsq_is_store ? STORE_REQ : IDLE;
          else if (mem2proc_response != 4'd0) next_state = FILL_WAIT;
          else                                next_state = FILL_REQ;
        end
      end
      FILL_REQ:  if (mem2proc_response != 4'd0) next_state = FILL_WAIT;
      FILL_WAIT: if (fill_done) next_state = req_is_store ? STORE_REQ : IDLE;
      STORE_REQ: if (mem2proc_response != 4'd0) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    lsq_response     = 4'd0;
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = 32'd0;
    proc2mem_data    = 64'd0;
    accept           = 1'b0;
    load_hit         = 1'b0;
    line_we          = 1'b0;
    line_wr_idx      = lsq_idx;
    line_wr_tag      = lsq_line_tag;
    line_wr_data     = 64'd0;
    case (state)
      IDLE: begin
        if (lsq_is_load || lsq_is_store) begin
          accept       = 1'b1;
          lsq_response = next_tag;
          if (lsq_hit && lsq_is_load) begin
            load_hit = 1'b1;
          end else if (lsq_hit) begin
            line_we      = 1'b1;
            line_wr_data = merge_word(line_data[lsq_idx], lsq_addr[2], lsq_store_data);
          end else begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = {lsq_addr[31:3], 3'b000};
          end
        end
      end
      FILL_REQ: begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = {req_block, 3'b000};
      end
      FILL_WAIT: begin
        if (fill_done) begin
          line_we      = 1'b1;
          line_wr_idx  = req_idx;
          line_wr_tag  = req_block[31:IDX_W+3];
          line_wr_data = req_is_store ? merge_word(mem2proc_data, req_word, req_data)
                                      : mem2proc_data;
        end
      end
      STORE_REQ: begin
        proc2mem_command = BUS_STORE;
        proc2mem_addr    = {req_block, 3'b000};
        proc2mem_data    = line_data[req_idx];
      end
      default: ;
    endcase
  end

  // lsq_tag / lsq_data_out default to zero so every completion is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_valid   <= '0;
      next_tag     <= 4'd1;
      mem_tag      <= 4'd0;
      req_id       <= 4'd0;
      req_is_store <= 1'b0;
      req_block    <= '0;
      req_word     <= 1'b0;
      req_data     <= 32'd0;
      lsq_tag      <= 4'd0;
      lsq_data_out <= 64'd0;
    end else begin
      lsq_tag      <= 4'd0;
      lsq_data_out <= 64'd0;
      if (accept) begin
        next_tag     <= (next_tag == 4'd15) ? 4'd1 : next_tag + 4'd1;
        req_id       <= next_tag;
        req_is_store <= lsq_is_store;
        req_block    <= lsq_addr[31:3];
        req_word     <= lsq_addr[2];
        req_data     <= lsq_store_data;
      end
      if (load_hit) begin
        lsq_tag      <= next_tag;
        lsq_data_out <= {32'd0, pick_word(line_data[lsq_idx], lsq_addr[2])};
      end
      if (proc2mem_command == BUS_LOAD && mem2proc_response != 4'd0)
        mem_tag <= mem2proc_response;
      if (line_we)
        line_valid[line_wr_idx] <= 1'b1;
      if (fill_done && !req_is_store) begin
        lsq_tag      <= req_id;
        lsq_data_out <= {32'd0, pick_word(mem2proc_data, req_word)};
      end
      if (state == STORE_REQ && mem2proc_response != 4'd0)
        lsq_tag <= req_id;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we && !reset) begin
      line_tag[line_wr_idx]  <= line_wr_tag;
      line_data[line_wr_idx] <= line_wr_data;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl: a reference cache/memory model predicts each
// completion, a tagged memory responder serves the bus, a monitor checks pulses.
module tb_dcache_ctrl;
  localparam logic [1:0] BUS_NONE  = 2'd0;
  localparam logic [1:0] BUS_LOAD  = 2'd1;
  localparam logic [1:0] BUS_STORE = 2'd2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  lsq_command = BUS_NONE;
  logic [31:0] lsq_addr = 32'd0;
  logic [31:0] lsq_store_data = 32'd0;
  logic [3:0]  lsq_response, lsq_tag;
  logic [63:0] lsq_data_out;
  logic [1:0]  proc2mem_command;
  logic [31:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response = 4'd0;
  logic [63:0] mem2proc_data = 64'd0;
  logic [3:0]  mem2proc_tag = 4'd0;

  always #5 clk = ~clk;

  dcache_ctrl #(.CACHE_LINES(32), .IDX_W(5)) dut (
    .clk(clk), .reset(reset),
    .lsq_command(lsq_command), .lsq_addr(lsq_addr), .lsq_store_data(lsq_store_data),
    .lsq_response(lsq_response), .lsq_tag(lsq_tag), .lsq_data_out(lsq_data_out),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_data(mem2proc_data), .mem2proc_tag(mem2proc_tag)
  );

  typedef struct { logic [3:0] tag; logic [63:0] data; int kind; int ref_cyc; } exp_t;
  typedef struct { logic [31:0] addr; logic [63:0] data; int cycles; } st_t;
  exp_t sb[$];
  st_t  st_q[$];

  int n_vec = 0, n_err = 0, cyc = 0;
  bit mon_en = 0;

  // Reference model: cache contents and backing memory as plain arrays.
  logic        mv [32];
  logic [23:0] mt [32];
  logic [63:0] md [32];
  logic [63:0] ref_mem [logic [28:0]];
  logic [63:0] bus_mem [logic [28:0]];
  logic [3:0]  exp_next = 4'd1;

  int rej_left = 0, ret_delay = 2, st_cycles = 0;
  int last_ret_cyc = -10, last_st_cyc = -10;
  logic [3:0]  mem_tag_sel = 4'd3;
  bit          hold_return = 0, pend = 0;
  int          pend_cnt = 0;
  logic [3:0]  pend_tag = 4'd0, inj_tag = 4'd0;
  logic [63:0] pend_data = 64'd0, inj_data = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] init_block(input logic [28:0] b);
    return {3'b101, b, 3'b010, b ^ 29'h15555555};
  endfunction

  function automatic logic [63:0] ref_read(input logic [28:0] b);
    if (ref_mem.exists(b)) return ref_mem[b];
    return init_block(b);
  endfunction

  function automatic logic [63:0] bus_read(input logic [28:0] b);
    if (bus_mem.exists(b)) return bus_mem[b];
    return init_block(b);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Tagged memory: accepts after rej_left refusals, returns a fill ret_delay+1 cycles later.
  always @(negedge clk) begin
    st_t s;
    logic [28:0] blk;
    mem2proc_response = 4'd0;
    mem2proc_tag      = 4'd0;
    mem2proc_data     = 64'd0;
    if (pend && !hold_return) begin
      if (pend_cnt <= 0) begin
        mem2proc_tag  = pend_tag;
        mem2proc_data = pend_data;
        pend          = 0;
        last_ret_cyc  = cyc;
      end else pend_cnt--;
    end else if (inj_tag != 4'd0) begin
      mem2proc_tag  = inj_tag;
      mem2proc_data = inj_data;
      inj_tag       = 4'd0;
    end
    if (proc2mem_command == BUS_STORE) st_cycles++;
    if (proc2mem_command == BUS_LOAD || proc2mem_command == BUS_STORE) begin
      if (rej_left > 0) rej_left--;
      else begin
        mem2proc_response = mem_tag_sel;
        blk = proc2mem_addr[31:3];
        if (proc2mem_command == BUS_LOAD) begin
          pend = 1; pend_cnt = ret_delay; pend_tag = mem_tag_sel; pend_data = bus_read(blk);
        end else begin
          if (st_q.size() == 0) checkOutput("unexpected_store", {62'd0, proc2mem_command}, 64'd0);
          else begin
            s = st_q.pop_front();
            checkOutput("store_addr", {32'd0, proc2mem_addr}, {32'd0, s.addr});
            checkOutput("store_data", proc2mem_data, s.data);
            checkOutput("store_cycles", st_cycles, s.cycles);
          end
          bus_mem[blk] = proc2mem_data;
          st_cycles    = 0;
          last_st_cyc  = cyc;
        end
        mem_tag_sel = 4'($urandom_range(15, 1));
      end
    end
  end

  // Every lsq_tag pulse must match the oldest prediction, in value and timing.
  always @(negedge clk) begin
    exp_t e;
    int rc;
    if (mon_en && lsq_tag !== 4'd0) begin
      if (sb.size() == 0) checkOutput("unexpected_tag", {60'd0, lsq_tag}, 64'd0);
      else begin
        e = sb.pop_front();
        rc = (e.kind == 0) ? e.ref_cyc : (e.kind == 1) ? last_ret_cyc : last_st_cyc;
        checkOutput("lsq_tag", {60'd0, lsq_tag}, {60'd0, e.tag});
        checkOutput("lsq_data_out", lsq_data_out, e.data);
        checkOutput("completion_cycle", cyc, rc + 1);
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] cmd, input logic [31:0] addr,
                               input logic [31:0] wdata, input int rej, output bit quick);
    logic [4:0]  idx;
    logic [23:0] tg;
    logic [28:0] blk;
    logic [63:0] line;
    bit          hit;
    exp_t        e;
    st_t         s;
    idx = addr[7:3]; tg = addr[31:8]; blk = addr[31:3];
    hit = mv[idx] && (mt[idx] == tg);
    if (!hit) begin mv[idx] = 1'b1; mt[idx] = tg; md[idx] = ref_read(blk); end
    line = md[idx];
    e.tag = exp_next; e.ref_cyc = cyc;
    if (cmd == BUS_LOAD) begin
      e.data = {32'd0, addr[2] ? line[63:32] : line[31:0]};
      e.kind = hit ? 0 : 1;
    end else begin
      line = addr[2] ? {wdata, line[31:0]} : {line[63:32], wdata};
      md[idx] = line; ref_mem[blk] = line;
      e.data = 64'd0; e.kind = 2;
      s.addr = {addr[31:3], 3'b000}; s.data = line; s.cycles = hit ? rej + 1 : 1;
      st_q.push_back(s);
    end
    sb.push_back(e);
    rej_left = rej;
    lsq_command = cmd; lsq_addr = addr; lsq_store_data = wdata;
    #1;
    checkOutput("lsq_response", {60'd0, lsq_response}, {60'd0, exp_next});
    checkOutput("bus_cmd_at_issue", {62'd0, proc2mem_command}, {62'd0, hit ? BUS_NONE : BUS_LOAD});
    if (!hit) checkOutput("bus_addr_at_issue", {32'd0, proc2mem_addr}, {32'd0, addr[31:3], 3'b000});
    exp_next = (exp_next == 4'd15) ? 4'd1 : exp_next + 4'd1;
    quick = hit && (cmd == BUS_LOAD);
    @(posedge clk); #1;
    lsq_command = BUS_NONE;
  endtask

  task automatic waitDone();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin @(posedge clk); #1; k++; end
    if (sb.size() != 0) begin
      checkOutput("completion_timeout", sb.size(), 0);
      sb.delete(); st_q.delete();
    end
  endtask

  task automatic doOp(input logic [1:0] cmd, input logic [31:0] addr,
                      input logic [31:0] wdata, input int rej);
    bit q;
    applyStimulus(cmd, addr, wdata, rej, q);
    if (!q) waitDone();
  endtask

  task automatic doReset();
    lsq_command = BUS_NONE;
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    exp_next = 4'd1;
    sb.delete(); st_q.delete();
    rej_left = 0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit q;
    logic [31:0] a;
    ref_mem[29'h20] = 64'h11112222_33334444;
    bus_mem[29'h20] = 64'h11112222_33334444;
    doReset();
    mon_en = 1;
    checkOutput("reset_lsq_tag", {60'd0, lsq_tag}, 64'd0);
    checkOutput("reset_lsq_data", lsq_data_out, 64'd0);
    checkOutput("reset_bus_cmd", {62'd0, proc2mem_command}, 64'd0);
    checkOutput("reset_bus_addr", {32'd0, proc2mem_addr}, 64'd0);
    checkOutput("reset_bus_data", proc2mem_data, 64'd0);
    checkOutput("reset_lsq_response", {60'd0, lsq_response}, 64'd0);

    // Miss with memory tag 3, then hit on the other word, then a rejected-twice store hit.
    mem_tag_sel = 4'd3; ret_delay = 2;
    doOp(BUS_LOAD, 32'h100, 32'd0, 0);
    doOp(BUS_LOAD, 32'h104, 32'd0, 0);
    doOp(BUS_STORE, 32'h100, 32'hDEADBEEF, 2);
    doOp(BUS_LOAD, 32'h100, 32'd0, 0);

    // Busy rejection and a stray memory tag while a fill is outstanding.
    mem_tag_sel = 4'd3; hold_return = 1;
    applyStimulus(BUS_LOAD, 32'h208, 32'd0, 0, q);
    lsq_command = BUS_LOAD; lsq_addr = 32'h104;
    #1;
    checkOutput("busy_response", {60'd0, lsq_response}, 64'd0);
    checkOutput("busy_bus_cmd", {62'd0, proc2mem_command}, 64'd0);
    inj_tag = 4'd7; inj_data = 64'hBAD0BAD0_BAD0BAD0;
    @(posedge clk); #1;
    lsq_command = BUS_NONE;
    repeat (3) begin @(posedge clk); #1; end
    hold_return = 0;
    waitDone();
    doOp(BUS_LOAD, 32'h104, 32'd0, 0);

    // Tag counter wrap across back-to-back hits.
    doReset();
    doOp(BUS_LOAD, 32'h100, 32'd0, 0);
    for (int i = 0; i < 16; i++) applyStimulus(BUS_LOAD, (i % 2 == 0) ? 32'h100 : 32'h104, 32'd0, 0, q);
    waitDone();

    // Reset while a fill is outstanding; the late return must be ignored.
    hold_return = 1;
    applyStimulus(BUS_LOAD, 32'h300, 32'd0, 0, q);
    repeat (2) begin @(posedge clk); #1; end
    doReset();
    hold_return = 0;
    repeat (6) begin @(posedge clk); #1; end
    doOp(BUS_LOAD, 32'h300, 32'd0, 0);

    // Randomized mix over a few indices with conflicting tags.
    for (int i = 0; i < 80; i++) begin
      a = {22'($urandom_range(2, 0)), 2'b00, 3'($urandom_range(3, 0)),
           1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)), 2'b00};
      a = {a[31:8] >> 2, a[7:0]};
      ret_delay = $urandom_range(4, 0);
      doOp(($urandom_range(1, 0) == 0) ? BUS_LOAD : BUS_STORE, {a[31:2], 2'($urandom_range(3, 0))},
           $urandom, $urandom_range(2, 0));
    end

    waitDone();
    repeat (5) begin @(posedge clk); #1; end
    checkOutput("scoreboard_drained", sb.size(), 0);
    checkOutput("stores_drained", st_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Blocking, direct-mapped, write-through/write-allocate data cache between the LSQ and the memory bus. It accepts one word-sized load or store per cycle from the LSQ and answers with a transaction tag. Hits are serviced from local storage. Misses fetch a 64-bit block from memory using the standard tagged memory protocol; stores are written through. It tracks one outstanding memory transaction and rejects LSQ requests while it is busy.

## Interface
- CACHE_LINES, 32, number of 64-bit lines (power of 2)
- IDX_W, 5, log2(CACHE_LINES)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- lsq_command  in  2  BUS_NONE / BUS_LOAD / BUS_STORE
- lsq_addr  in  32  byte address; [1:0] ignored, [2] word select, [IDX_W+2:3] index, [31:IDX_W+3] tag
- lsq_store_data  in  32  store word
- lsq_response  out  4  combinational; 0 = rejected, else transaction tag assigned this cycle
- lsq_tag  out  4  registered; nonzero = transaction with this tag completed this cycle
- lsq_data_out  out  64  registered; [31:0] = loaded word, [63:32] = 0; 0 for stores
- proc2mem_command  out  2  combinational bus command
- proc2mem_addr  out  32  block-aligned address ([2:0] = 0)
- proc2mem_data  out  64  block to store
- mem2proc_response  in  4  0 = memory rejected, else memory tag
- mem2proc_data  in  64  returning block
- mem2proc_tag  in  4  nonzero = data for that memory tag is valid

## Operation
- Storage: per line valid bit, tag, 64-bit data. Hit = valid && tag match.
- Tag counter next_tag: reset value 1. Increments on every accepted LSQ request. Wraps 15 -> 1 and never produces 0.
- FSM states: IDLE, FILL_REQ, FILL_WAIT, STORE_REQ.
- IDLE, lsq_command == BUS_NONE: lsq_response = 0.
- IDLE, load hit: accept. Next cycle lsq_tag = T and lsq_data_out = selected word. Stay in IDLE.
- IDLE, load or store miss: accept and latch the request (cmd, addr, data, T). Drive BUS_LOAD in the same cycle. If mem2proc_response != 0, latch mem_tag and go to FILL_WAIT; otherwise go to FILL_REQ.
- IDLE, store hit: accept and merge the word into the line. Go to STORE_REQ.
- FILL_REQ: re-drive BUS_LOAD every cycle. Go to FILL_WAIT on nonzero response and latch mem_tag.
- FILL_WAIT: when mem2proc_tag == mem_tag (and nonzero), write the line (valid = 1, tag, data).
  - For a load: next cycle lsq_tag = T and lsq_data_out = word from mem2proc_data. Go to IDLE.
  - For a store: merge the store word into the written line. Go to STORE_REQ.
- STORE_REQ: drive BUS_STORE with the line address and merged line data. On nonzero response, next cycle lsq_tag = T and lsq_data_out = 0. Go to IDLE.
- In any state other than IDLE, lsq_response = 0 for every request, hits included.
- proc2mem_command = BUS_NONE whenever no request is being driven.
- Mismatched or zero mem2proc_tag is ignored.

## Timing
- Reset: all valid bits 0, state IDLE, next_tag = 1, mem_tag = 0, lsq_tag = 0, lsq_data_out = 0, proc2mem_command = BUS_NONE, proc2mem_addr/data = 0, lsq_response = 0.
- Load hit latency: accepted in cycle N, result in cycle N+1.
- Load miss latency: memory data in cycle M, result in cycle M+1. Line is readable as a hit from cycle M+1.
- Store completion: memory accepts the store in cycle S, lsq_tag pulses in cycle S+1.
- lsq_tag is a single-cycle pulse per transaction.
- A new request may be accepted in the same cycle an lsq_tag pulse is output (that cycle is IDLE).
- Reset during FILL_WAIT: abandon the transaction. A later return of the old mem_tag is ignored and no line is written.
- Same-index conflict: a fill overwrites whatever line is resident (direct-mapped, no dirty state).

## Test plan
- Reset, then load 0x100 with memory accepting tag 3 and returning 0x11112222_33334444 three cycles later: lsq_response = 1; proc2mem BUS_LOAD addr 0x100; lsq_tag = 1 with data 0x33334444 one cycle after the return.
- Load 0x104 immediately after: hit, lsq_response = 2, next cycle data 0x11112222, no bus activity.
- Store 0xDEADBEEF to 0x100 (hit), memory rejecting twice then accepting: BUS_STORE driven three cycles with data 0x11112222_DEADBEEF; lsq_tag = 3 one cycle after acceptance; a later load 0x100 returns 0xDEADBEEF.
- Request issued while in FILL_WAIT: lsq_response = 0, no state change. Stray mem2proc_tag 7 while waiting for 3: ignored.
- Accept 16 hits back to back: response tags 1..15, then 1; 0 never appears.
- Reset asserted in FILL_WAIT, old mem tag returned afterwards: no lsq_tag pulse, and a load to that address misses.
